// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the branch resolution controller: transfer kinds,
// branch compare codes (RV32 funct3) and sequencer states.
package branch_resolve_ctrl_pkg;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BR   = 2'd1;
  localparam logic [1:0] KIND_JAL  = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EVAL     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  function automatic logic is_jump(input logic [1:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

endpackage

// File: rtl/branch_comp.sv
// Conditional-branch comparator; unknown compare codes resolve as not taken.
module branch_comp
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_in1,
  input  logic [XLEN-1:0] data_in2,
  input  logic [2:0]      branch_op,
  output logic            branch_out
);

  always_comb begin
    branch_out = 1'b0;
    case (branch_op)
      OP_BEQ:  branch_out = (data_in1 == data_in2);
      OP_BNE:  branch_out = (data_in1 != data_in2);
      OP_BLT:  branch_out = ($signed(data_in1) <  $signed(data_in2));
      OP_BGE:  branch_out = ($signed(data_in1) >= $signed(data_in2));
      OP_BLTU: branch_out = (data_in1 <  data_in2);
      OP_BGEU: branch_out = (data_in1 >= data_in2);
      default: branch_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves one branch/jump at a time: latch in IDLE, evaluate in EVAL,
// hold the redirect to fetch in REDIRECT until it is accepted.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [1:0]       id_kind,
  input  logic [2:0]       id_branch_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             rs_hazard,
  input  logic             kill,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             fetch_ready,
  output logic             flush,
  output logic             link_valid,
  output logic [XLEN-1:0]  link_data,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [1:0]       state_reg, state_next;
  logic [XLEN-1:0]  pc_q, imm_q, rs1_q, rs2_q;
  logic [1:0]       kind_q;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  redirect_pc_reg;
  logic [CNT_W-1:0] br_cnt_reg, taken_cnt_reg;

  logic             accept, in_eval, cmp_taken, taken;
  logic [XLEN-1:0]  sum_pc, sum_rs1, target;

  branch_comp #(.XLEN(XLEN)) u_branch_comp (
    .data_in1  (rs1_q),
    .data_in2  (rs2_q),
    .branch_op (op_q),
    .branch_out(cmp_taken)
  );

  assign id_ready = (state_reg == ST_IDLE) && !rs_hazard && !kill;
  assign accept   = id_valid && id_ready && (id_kind != KIND_NONE);

  // EVAL work is void if the instruction is killed or reset in that cycle.
  assign in_eval  = (state_reg == ST_EVAL) && !kill && !rst;

  assign sum_pc  = pc_q + imm_q;
  assign sum_rs1 = rs1_q + imm_q;
  assign target  = (kind_q == KIND_JALR) ? {sum_rs1[XLEN-1:1], 1'b0} : sum_pc;
  assign taken   = (kind_q == KIND_BR) ? cmp_taken : 1'b1;

  assign link_valid   = in_eval && is_jump(kind_q);
  assign link_data    = link_valid ? (pc_q + XLEN'(4)) : '0;
  assign misalign_exc = in_eval && taken && target[1];
  assign misalign_pc  = misalign_exc ? target : '0;

  assign redirect_valid = (state_reg == ST_REDIRECT);
  assign flush          = redirect_valid;
  assign redirect_pc    = redirect_pc_reg;
  assign br_cnt         = br_cnt_reg;
  assign taken_cnt      = taken_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (accept) state_next = ST_EVAL;
      ST_EVAL:     state_next = (taken && !target[1]) ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: if (fetch_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (kill) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pc_q            <= '0;
      imm_q           <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      kind_q          <= KIND_NONE;
      op_q            <= '0;
      redirect_pc_reg <= '0;
      br_cnt_reg      <= '0;
      taken_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pc_q   <= id_pc;
        imm_q  <= id_imm;
        rs1_q  <= rs1_data;
        rs2_q  <= rs2_data;
        kind_q <= id_kind;
        op_q   <= id_branch_op;
      end
      if (in_eval && taken && !target[1]) redirect_pc_reg <= target;
      // Misaligned taken branches still count as taken.
      if (in_eval && (kind_q == KIND_BR)) begin
        br_cnt_reg <= br_cnt_reg + CNT_W'(1);
        if (cmp_taken) taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: transaction-level outcome model
// checked every cycle, plus hand-computed literal expectations.
module tb_branch_resolve_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [1:0] K_NONE = 2'd0, K_BR = 2'd1, K_JAL = 2'd2, K_JALR = 2'd3;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101,
                         BLTU = 3'b110, BGEU = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic             id_ready;
  logic [1:0]       id_kind = 2'd0;
  logic [2:0]       id_branch_op = 3'd0;
  logic [XLEN-1:0]  id_pc = '0, id_imm = '0, rs1_data = '0, rs2_data = '0;
  logic             rs_hazard = 1'b0, kill = 1'b0, fetch_ready = 1'b0;
  logic             redirect_valid, flush, link_valid, misalign_exc;
  logic [XLEN-1:0]  redirect_pc, link_data, misalign_pc;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_kind(id_kind), .id_branch_op(id_branch_op), .id_pc(id_pc), .id_imm(id_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs_hazard(rs_hazard), .kill(kill),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_ready(fetch_ready),
    .flush(flush), .link_valid(link_valid), .link_data(link_data),
    .misalign_exc(misalign_exc), .misalign_pc(misalign_pc),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          jump;
    bit          br;
    bit          taken;
    logic [31:0] target;
    logic [31:0] link;
  } outcome_t;

  // What an instruction must do, straight from the ISA rules.
  function automatic outcome_t resolve(input logic [1:0] k, input logic [2:0] op,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [31:0] a, input logic [31:0] b);
    outcome_t o;
    int sa, sb;
    sa = a;
    sb = b;
    o.br   = (k == K_BR);
    o.jump = (k == K_JAL) || (k == K_JALR);
    o.link = pc + 32'd4;
    o.taken = 1'b1;
    if (o.br) begin
      if (op == BEQ)       o.taken = (a == b);
      else if (op == BNE)  o.taken = (a != b);
      else if (op == BLT)  o.taken = (sa < sb);
      else if (op == BGE)  o.taken = (sa >= sb);
      else if (op == BLTU) o.taken = (a < b);
      else if (op == BGEU) o.taken = (a >= b);
      else                 o.taken = 1'b0;
    end
    if (k == K_JALR) o.target = (a + imm) & 32'hFFFF_FFFE;
    else             o.target = pc + imm;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one instruction in flight (being evaluated) or one redirect pending.
  bit       m_eval = 1'b0, m_redir = 1'b0;
  outcome_t m_o;
  logic [31:0] m_rpc = '0;
  int       m_br = 0, m_tk = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_eval = 1'b0; m_redir = 1'b0; m_br = 0; m_tk = 0;
    end else if (kill) begin
      m_eval = 1'b0; m_redir = 1'b0;
    end else if (m_eval) begin
      if (m_o.br) begin
        m_br = (m_br + 1) % 16;
        if (m_o.taken) m_tk = (m_tk + 1) % 16;
      end
      if (m_o.taken && !m_o.target[1]) begin
        m_redir = 1'b1;
        m_rpc   = m_o.target;
      end
      m_eval = 1'b0;
    end else if (m_redir) begin
      if (fetch_ready) m_redir = 1'b0;
    end else if (id_valid && !rs_hazard && id_kind != K_NONE) begin
      m_eval = 1'b1;
      m_o = resolve(id_kind, id_branch_op, id_pc, id_imm, rs1_data, rs2_data);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      bit e_link, e_mis;
      e_link = m_eval && m_o.jump && !kill && !rst;
      e_mis  = m_eval && m_o.taken && m_o.target[1] && !kill && !rst;
      chk("m_id_ready", {31'd0, id_ready}, {31'd0, !m_eval && !m_redir && !rs_hazard && !kill});
      chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
      chk("m_flush", {31'd0, flush}, {31'd0, m_redir});
      chk("m_link_valid", {31'd0, link_valid}, {31'd0, e_link});
      chk("m_misalign_exc", {31'd0, misalign_exc}, {31'd0, e_mis});
      chk("m_br_cnt", {28'd0, br_cnt}, m_br);
      chk("m_taken_cnt", {28'd0, taken_cnt}, m_tk);
      if (m_redir) chk("m_redirect_pc", redirect_pc, m_rpc);
      if (e_link)  chk("m_link_data", link_data, m_o.link);
      if (e_mis)   chk("m_misalign_pc", misalign_pc, m_o.target);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_kind = k; id_branch_op = op;
    id_pc = pc; id_imm = imm; rs1_data = a; rs2_data = b;
    step();
    id_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    run_chk = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

    // BLT taken: redirect two cycles after accept.
    fetch_ready = 1'b1;
    issue(K_BR, BLT, 32'h0000_1000, 32'h0000_0040, 32'hff78_6510, 32'h1096_bc81);
    chk("blt_eval_rv", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("blt_rv", {31'd0, redirect_valid}, 32'd1);
    chk("blt_rpc", redirect_pc, 32'h0000_1040);
    chk("blt_flush", {31'd0, flush}, 32'd1);
    chk("blt_br_cnt", {28'd0, br_cnt}, 32'd1);
    chk("blt_taken_cnt", {28'd0, taken_cnt}, 32'd1);
    step();
    chk("blt_done_rv", {31'd0, redirect_valid}, 32'd0);

    // BLTU not taken, then an unknown-op branch accepted at accept+2, then NONE.
    do_reset();
    issue(K_BR, BLTU, 32'h0000_1000, 32'h0000_0040, 32'hff78_6510, 32'h1096_bc81);
    chk("bltu_eval_ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("bltu_idle_ready", {31'd0, id_ready}, 32'd1);
    chk("bltu_rv", {31'd0, redirect_valid}, 32'd0);
    chk("bltu_br_cnt", {28'd0, br_cnt}, 32'd1);
    chk("bltu_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    issue(K_BR, 3'b010, 32'h0000_2000, 32'h0000_0010, 32'd5, 32'd5);
    chk("b2b_accepted", {31'd0, id_ready}, 32'd0);
    step();
    chk("badop_br_cnt", {28'd0, br_cnt}, 32'd2);
    chk("badop_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    issue(K_NONE, BEQ, 32'h0000_3000, 32'h0000_0010, 32'd0, 32'd0);
    chk("none_ignored", {31'd0, id_ready}, 32'd1);

    // JALR with fetch stalled for three cycles.
    do_reset();
    fetch_ready = 1'b0;
    issue(K_JALR, BEQ, 32'h0000_0200, 32'h0000_0001, 32'h497b_dc53, 32'd0);
    chk("jalr_link_valid", {31'd0, link_valid}, 32'd1);
    chk("jalr_link_data", link_data, 32'h0000_0204);
    chk("jalr_misalign", {31'd0, misalign_exc}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("jalr_hold_rv", {31'd0, redirect_valid}, 32'd1);
      chk("jalr_hold_rpc", redirect_pc, 32'h497b_dc54);
      chk("jalr_hold_flush", {31'd0, flush}, 32'd1);
      step();
    end
    chk("jalr_last_rv", {31'd0, redirect_valid}, 32'd1);
    fetch_ready = 1'b1;
    step();
    chk("jalr_released_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jalr_no_link", {31'd0, link_valid}, 32'd0);

    // JAL to a misaligned target.
    do_reset();
    issue(K_JAL, BEQ, 32'h0000_0100, 32'h0000_0006, 32'd0, 32'd0);
    chk("jal_misalign_exc", {31'd0, misalign_exc}, 32'd1);
    chk("jal_misalign_pc", misalign_pc, 32'h0000_0106);
    chk("jal_link_valid", {31'd0, link_valid}, 32'd1);
    chk("jal_link_data", link_data, 32'h0000_0104);
    step();
    chk("jal_no_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jal_idle_ready", {31'd0, id_ready}, 32'd1);
    chk("jal_br_cnt", {28'd0, br_cnt}, 32'd0);

    // Kill in EVAL, kill in REDIRECT, reset in REDIRECT.
    do_reset();
    issue(K_BR, BEQ, 32'h0000_0300, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678);
    kill = 1'b1;
    #1;
    chk("kill_eval_ready", {31'd0, id_ready}, 32'd0);
    step();
    kill = 1'b0;
    #1;
    chk("kill_no_rv", {31'd0, redirect_valid}, 32'd0);
    chk("kill_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("kill_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    chk("kill_ready_back", {31'd0, id_ready}, 32'd1);
    fetch_ready = 1'b0;
    issue(K_BR, BEQ, 32'h0000_0300, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678);
    step();
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_redir_rv", {31'd0, redirect_valid}, 32'd0);
    issue(K_BR, BEQ, 32'h0000_0300, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678);
    step();
    chk("beq2_rpc", redirect_pc, 32'h0000_0320);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_rpc", redirect_pc, 32'd0);
    chk("rst_mid_link", {31'd0, link_valid}, 32'd0);
    chk("rst_mid_link_data", link_data, 32'd0);
    chk("rst_mid_misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst_mid_misalign_pc", misalign_pc, 32'd0);
    chk("rst_mid_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("rst_mid_taken_cnt", {28'd0, taken_cnt}, 32'd0);

    // Operand hazard blocks accept; then 16 taken BNE wrap the 4-bit counters.
    do_reset();
    rs_hazard = 1'b1;
    id_valid = 1'b1; id_kind = K_BR; id_branch_op = BNE;
    id_pc = 32'h0000_0400; id_imm = 32'd8; rs1_data = 32'd1; rs2_data = 32'd2;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hazard_ready", {31'd0, id_ready}, 32'd0);
      step();
    end
    rs_hazard = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("hazard_no_accept", {28'd0, br_cnt}, 32'd0);
    chk("hazard_ready_back", {31'd0, id_ready}, 32'd1);
    fetch_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(K_BR, BNE, 32'h0000_0400, 32'd8, 32'd1, 32'd2);
      step();
      if (i == 14) begin
        chk("wrap_pre_br", {28'd0, br_cnt}, 32'd15);
        chk("wrap_pre_taken", {28'd0, taken_cnt}, 32'd15);
      end
      step();
    end
    chk("wrap_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("wrap_taken_cnt", {28'd0, taken_cnt}, 32'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
